sad_block_accumulator: RTL and testbench



---
 rtl/sad_block_accumulator.sv | 163 ++++++++++++++++
 tb/tb_sad_block_accumulator.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_block_accumulator.sv
// Streaming SAD engine: |pix_a - pix_b| per pair, saturating sum over N_PIX pairs per block.
// Optional macro SAD_MIN_TRACK_EN adds best-candidate (minimum SAD) tracking.
module sad_block_accumulator #(
  parameter int PIX_W = 8,
  parameter int N_PIX = 256,
  parameter int SAD_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] pix_a,
  input  logic [PIX_W-1:0] pix_b,
  output logic [SAD_W-1:0] sad,
  output logic             sad_valid,
  output logic             busy
`ifdef SAD_MIN_TRACK_EN
  ,
  input  logic             min_clear,
  output logic [SAD_W-1:0] best_sad,
  output logic [7:0]       best_idx
`endif
);

  localparam int CNT_W = (N_PIX > 2) ? $clog2(N_PIX) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_busy;
  logic             r_sad_valid;
  logic [CNT_W-1:0] r_cnt;
  logic             r_s1_valid;
  logic [PIX_W-1:0] r_abs;
  logic [SAD_W-1:0] r_acc;

  logic             w_hs;
  logic             w_start_ok;
  logic             w_last;
  logic [PIX_W:0]   w_diff;
  logic [PIX_W-1:0] w_abs;
  logic [SAD_W:0]   w_sum;

  assign w_hs       = in_valid & r_in_ready;
  assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_DONE));
  assign w_last     = (r_cnt == CNT_W'(N_PIX - 1));

  // Top bit of the 9-bit difference is the borrow: set means pix_a < pix_b.
  assign w_diff = {1'b0, pix_a} - {1'b0, pix_b};
  assign w_abs  = w_diff[PIX_W] ? PIX_W'(-w_diff) : w_diff[PIX_W-1:0];
  assign w_sum  = {1'b0, r_acc} + (SAD_W + 1)'(r_abs);

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_sad_valid <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_sad_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_ACCUM;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
          end
        end
        S_ACCUM: begin
          if (w_hs) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        // Wait until the last stage-1 term has been folded into the accumulator.
        S_DRAIN: begin
          if (!r_s1_valid) begin
            r_state     <= S_DONE;
            r_sad_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            r_state    <= S_ACCUM;
            r_in_ready <= 1'b1;
            r_cnt      <= '0;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_abs      <= '0;
      r_acc      <= '0;
    end else if (w_start_ok) begin
      r_s1_valid <= 1'b0;
      r_acc      <= '0;
    end else begin
      r_s1_valid <= w_hs;
      if (w_hs) r_abs <= w_abs;
      if (r_s1_valid) r_acc <= w_sum[SAD_W] ? {SAD_W{1'b1}} : w_sum[SAD_W-1:0];
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign sad_valid = r_sad_valid;
  assign sad       = r_acc;

`ifdef SAD_MIN_TRACK_EN
  logic [7:0]       r_cand;
  logic [SAD_W-1:0] r_best_sad;
  logic [7:0]       r_best_idx;

  // Compare happens while sad_valid is high, so results land as the pulse ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand     <= '0;
      r_best_sad <= {SAD_W{1'b1}};
      r_best_idx <= '0;
    end else if (min_clear) begin
      r_cand     <= '0;
      r_best_sad <= {SAD_W{1'b1}};
      r_best_idx <= '0;
    end else if (r_sad_valid) begin
      r_cand <= r_cand + 8'd1;
      if (r_acc < r_best_sad) begin
        r_best_sad <= r_acc;
        r_best_idx <= r_cand;
      end
    end
  end

  assign best_sad = r_best_sad;
  assign best_idx = r_best_idx;
`endif

endmodule

// File: tb/tb_sad_block_accumulator.sv
// Self-checking bench for sad_block_accumulator: three parameterisations driven from shared
// pixel inputs, checked every cycle against a rule-level model plus literal expectations.
module tb_sad_block_accumulator;

  localparam int N_ARR[3] = '{256, 4, 4};
  localparam int W_ARR[3] = '{16, 16, 8};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       min_clear = 1'b0;
  logic [7:0] pix_a = 8'd0;
  logic [7:0] pix_b = 8'd0;
  logic       start_v[3];

  logic        rdy[3];
  logic        bsy[3];
  logic        sv[3];
  logic [15:0] sad0, sad1;
  logic [7:0]  sad2;
  logic [15:0] sad_w[3];
  logic [15:0] bs0, bs1;
  logic [7:0]  bs2;
  logic [7:0]  bi[3];
  logic [15:0] best_w[3];

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  sad_block_accumulator #(.PIX_W(8), .N_PIX(256), .SAD_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in_valid(in_valid), .in_ready(rdy[0]),
    .pix_a(pix_a), .pix_b(pix_b), .sad(sad0), .sad_valid(sv[0]), .busy(bsy[0])
`ifdef SAD_MIN_TRACK_EN
    , .min_clear(min_clear), .best_sad(bs0), .best_idx(bi[0])
`endif
  );

  sad_block_accumulator #(.PIX_W(8), .N_PIX(4), .SAD_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in_valid(in_valid), .in_ready(rdy[1]),
    .pix_a(pix_a), .pix_b(pix_b), .sad(sad1), .sad_valid(sv[1]), .busy(bsy[1])
`ifdef SAD_MIN_TRACK_EN
    , .min_clear(min_clear), .best_sad(bs1), .best_idx(bi[1])
`endif
  );

  sad_block_accumulator #(.PIX_W(8), .N_PIX(4), .SAD_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in_valid(in_valid), .in_ready(rdy[2]),
    .pix_a(pix_a), .pix_b(pix_b), .sad(sad2), .sad_valid(sv[2]), .busy(bsy[2])
`ifdef SAD_MIN_TRACK_EN
    , .min_clear(min_clear), .best_sad(bs2), .best_idx(bi[2])
`endif
  );

  assign sad_w[0] = sad0;
  assign sad_w[1] = sad1;
  assign sad_w[2] = {8'd0, sad2};
`ifdef SAD_MIN_TRACK_EN
  assign best_w[0] = bs0;
  assign best_w[1] = bs1;
  assign best_w[2] = {8'd0, bs2};
`else
  assign best_w[0] = 16'd0;
  assign best_w[1] = 16'd0;
  assign best_w[2] = 16'd0;
  assign bi[0] = 8'd0;
  assign bi[1] = 8'd0;
  assign bi[2] = 8'd0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Rule-level model: per instance, what must be visible in the cycle after each edge.
  bit m_ready[3], m_busy[3], m_valid[3];
  int m_cnt[3], m_sum[3], m_drain[3];
  int m_cand[3], m_best[3], m_bidx[3];

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_ready[i] = 0; m_busy[i] = 0; m_valid[i] = 0;
      m_cnt[i] = 0; m_sum[i] = 0; m_drain[i] = 0;
      m_cand[i] = 0; m_best[i] = (1 << W_ARR[i]) - 1; m_bidx[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    bit pv, pbusy, hs;
    int d, s, maxv;
    pv    = m_valid[i];
    pbusy = m_busy[i];
    hs    = in_valid && m_ready[i];
    maxv  = (1 << W_ARR[i]) - 1;
    if (min_clear) begin
      m_best[i] = maxv; m_bidx[i] = 0; m_cand[i] = 0;
    end else if (pv) begin
      if (m_sum[i] < m_best[i]) begin
        m_best[i] = m_sum[i]; m_bidx[i] = m_cand[i];
      end
      m_cand[i] = (m_cand[i] + 1) % 256;
    end
    m_valid[i] = 0;
    if (start_v[i] && (!pbusy || pv)) begin
      m_sum[i] = 0; m_cnt[i] = 0; m_ready[i] = 1; m_busy[i] = 1; m_drain[i] = 0;
    end else if (hs) begin
      d = (pix_a > pix_b) ? int'(pix_a) - int'(pix_b) : int'(pix_b) - int'(pix_a);
      s = m_sum[i] + d;
      m_sum[i] = (s > maxv) ? maxv : s;
      m_cnt[i]++;
      if (m_cnt[i] == N_ARR[i]) begin
        m_ready[i] = 0; m_drain[i] = 2;
      end
    end else if (m_drain[i] > 0) begin
      m_drain[i]--;
      if (m_drain[i] == 0) m_valid[i] = 1;
    end else if (pv) begin
      m_busy[i] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else for (int i = 0; i < 3; i++) model_step(i);
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("in_ready[%0d]", i), 32'(rdy[i]), 32'(m_ready[i]));
      check($sformatf("busy[%0d]", i), 32'(bsy[i]), 32'(m_busy[i]));
      check($sformatf("sad_valid[%0d]", i), 32'(sv[i]), 32'(m_valid[i]));
      if (m_valid[i]) check($sformatf("sad[%0d]", i), 32'(sad_w[i]), 32'(m_sum[i]));
`ifdef SAD_MIN_TRACK_EN
      check($sformatf("best_sad[%0d]", i), 32'(best_w[i]), 32'(m_best[i]));
      check($sformatf("best_idx[%0d]", i), 32'(bi[i]), 32'(m_bidx[i]));
`endif
    end
  end

  logic [7:0] qa[$], qb[$];

  task automatic fill_const(input int n, input logic [7:0] a, input logic [7:0] b);
    qa.delete(); qb.delete();
    for (int k = 0; k < n; k++) begin qa.push_back(a); qb.push_back(b); end
  endtask

  // Called at a negedge; asserts start there, then feeds qa/qb.
  // gap: 0 none, 1 in_valid low every other cycle, 2 random gaps plus ignored start pokes.
  task automatic drive_block(input int inst, input int gap, output int c0);
    int k, budget;
    bit hs;
    start_v[inst] = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start_v[inst] = 1'b0;
    k = 0;
    budget = 4 * qa.size() + 50;
    while (k < qa.size() && budget > 0) begin
      case (gap)
        0: in_valid = 1'b1;
        1: in_valid = ~in_valid;
        default: begin
          in_valid = ($urandom_range(0, 3) != 0);
          start_v[inst] = ($urandom_range(0, 15) == 0);
        end
      endcase
      pix_a = qa[k];
      pix_b = qb[k];
      hs = in_valid && rdy[inst];
      @(negedge clk);
      if (hs) k++;
      budget--;
    end
    in_valid = 1'b0;
    start_v[inst] = 1'b0;
    if (k < qa.size()) check("feed_timeout", 32'(k), 32'(qa.size()));
  endtask

  task automatic wait_done(input int inst, output int c1);
    bit found;
    found = 0;
    c1 = 0;
    for (int t = 0; t < 20 && !found; t++) begin
      if (sv[inst]) begin found = 1; c1 = cyc; end
      else @(negedge clk);
    end
    if (!found) check("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int c0, c1;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(rdy[0]), 32'd0);
    check("rst_busy", 32'(bsy[0]), 32'd0);
    check("rst_sad", 32'(sad0), 32'd0);
    check("rst_sad_valid", 32'(sv[0]), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Equal pixels: zero SAD, pulse 259 cycles after the start cycle.
    fill_const(256, 8'h5A, 8'h5A);
    drive_block(0, 0, c0);
    wait_done(0, c1);
    check("zero_sad", 32'(sad0), 32'd0);
    check("latency_259", 32'(c1 - c0), 32'd259);
    check("ready_in_done", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    check("valid_one_cycle", 32'(sv[0]), 32'd0);
    check("sad_holds", 32'(sad0), 32'd0);

    fill_const(256, 8'd255, 8'd0);
    drive_block(0, 0, c0);
    wait_done(0, c1);
    check("max_pos_sad", 32'(sad0), 32'd65280);
    @(negedge clk);

    fill_const(256, 8'd0, 8'd255);
    drive_block(0, 2, c0);
    wait_done(0, c1);
    check("max_borrow_sad", 32'(sad0), 32'd65280);
    @(negedge clk);

    // Small block with alternating gaps: 7 + 7 + 255 + 0.
    qa = '{8'd10, 8'd3, 8'd0, 8'd128};
    qb = '{8'd3, 8'd10, 8'd255, 8'd128};
    drive_block(1, 1, c0);
    wait_done(1, c1);
    check("mix_sad", 32'(sad1), 32'd269);
    check("mix_ready_done", 32'(rdy[1]), 32'd0);
    @(negedge clk);

    // Same pairs into the 8-bit accumulator: 269 clips at 255.
    drive_block(2, 1, c0);
    wait_done(2, c1);
    check("mix_sad_w8", 32'(sad2), 32'd255);
    @(negedge clk);

    fill_const(4, 8'd100, 8'd0);
    drive_block(2, 0, c0);
    wait_done(2, c1);
    check("sat_sad_w8", 32'(sad2), 32'd255);

    // Random blocks, several back-to-back, checked by the model.
    for (int b = 0; b < 9; b++) begin
      int inst, n;
      inst = b % 3;
      n = N_ARR[inst];
      qa.delete(); qb.delete();
      for (int k = 0; k < n; k++) begin
        qa.push_back(8'($urandom_range(0, 255)));
        qb.push_back(8'($urandom_range(0, 255)));
      end
      if (b % 2 == 0) @(negedge clk);
      drive_block(inst, 2, c0);
      wait_done(inst, c1);
    end
    @(negedge clk);

    // Reset in the middle of a block.
    fill_const(100, 8'd200, 8'd17);
    drive_block(0, 0, c0);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(rdy[0]), 32'd0);
    check("midrst_busy", 32'(bsy[0]), 32'd0);
    check("midrst_sad", 32'(sad0), 32'd0);
    check("midrst_valid", 32'(sv[0]), 32'd0);
`ifdef SAD_MIN_TRACK_EN
    check("midrst_best_sad", 32'(bs0), 32'hFFFF);
    check("midrst_best_idx", 32'(bi[0]), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_const(256, 8'd33, 8'd33);
    drive_block(0, 1, c0);
    wait_done(0, c1);
    check("post_rst_sad", 32'(sad0), 32'd0);
    @(negedge clk);

`ifdef SAD_MIN_TRACK_EN
    min_clear = 1'b1;
    @(negedge clk);
    min_clear = 1'b0;
    fill_const(256, 8'd0, 8'd0);
    qa[0] = 8'd250; qa[1] = 8'd250;
    drive_block(0, 0, c0);
    wait_done(0, c1);
    check("blk0_sad", 32'(sad0), 32'd500);
    fill_const(256, 8'd0, 8'd0);
    qa[0] = 8'd150; qa[1] = 8'd150;
    drive_block(0, 0, c0);
    wait_done(0, c1);
    check("blk1_sad", 32'(sad0), 32'd300);
    fill_const(256, 8'd0, 8'd0);
    qb[5] = 8'd150; qa[9] = 8'd150;
    drive_block(0, 0, c0);
    wait_done(0, c1);
    check("blk2_sad", 32'(sad0), 32'd300);
    @(negedge clk);
    check("best_sad_300", 32'(bs0), 32'd300);
    check("best_idx_1", 32'(bi[0]), 32'd1);
    min_clear = 1'b1;
    @(negedge clk);
    min_clear = 1'b0;
    check("clr_best_sad", 32'(bs0), 32'hFFFF);
    check("clr_best_idx", 32'(bi[0]), 32'd0);
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
